// File: rtl/flash_boot_loader.sv
// flash_boot_loader: copies LEN_BYTES from QSPI flash into memory as little-endian 32-bit words.
// Memory backpressure pauses the flash stream, which restarts at the next unread byte.
module flash_boot_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h100000,
    parameter int unsigned LEN_BYTES  = 4096,
    parameter logic [31:0] MEM_BASE   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flash_setup_done,
    input  logic        flash_data_ready,
    input  logic [7:0]  flash_data,
    output logic [23:0] flash_addr,
    output logic        flash_do_read,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        busy,
    output logic        done
);
    localparam logic [2:0] WAIT_SETUP = 3'd0;
    localparam logic [2:0] READ       = 3'd1;
    localparam logic [2:0] PAUSE      = 3'd2;
    localparam logic [2:0] FLUSH      = 3'd3;
    localparam logic [2:0] DONE       = 3'd4;

    logic [2:0]  state, state_nxt;
    logic [23:0] rd_cnt;
    logic [1:0]  pk_cnt;
    logic [31:0] pack;
    logic        slot_free, take, last, load_full, load_part;

    assign slot_free = !mem_valid || mem_ready;
    assign take      = state == READ && flash_data_ready && (pk_cnt != 2'd3 || slot_free);
    assign last      = ({1'b0, rd_cnt} + 25'd1) == 25'(LEN_BYTES);
    assign load_full = take && pk_cnt == 2'd3;
    assign load_part = state == FLUSH && pk_cnt != 2'd0 && slot_free;

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_SETUP: state_nxt = flash_setup_done ? READ : WAIT_SETUP;
            READ:       state_nxt = (take && last) ? FLUSH : (flash_data_ready && !take) ? PAUSE : READ;
            PAUSE:      state_nxt = slot_free ? READ : PAUSE;
            FLUSH:      state_nxt = (pk_cnt == 2'd0 && !mem_valid) ? DONE : FLUSH;
            default:    state_nxt = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_SETUP;
            flash_do_read <= 1'b0;
            flash_addr    <= FLASH_BASE;
            mem_valid     <= 1'b0;
            mem_addr      <= MEM_BASE;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_cnt        <= '0;
            pk_cnt        <= '0;
            pack          <= '0;
        end else begin
            state         <= state_nxt;
            flash_do_read <= state_nxt == READ;
            busy          <= state_nxt == READ || state_nxt == PAUSE || state_nxt == FLUSH;
            done          <= state_nxt == DONE;
            // the start address is frozen for the whole flash transaction
            if (state != READ || state_nxt != READ)
                flash_addr <= FLASH_BASE + rd_cnt;
            if (take) begin
                rd_cnt                     <= rd_cnt + 24'd1;
                pk_cnt                     <= pk_cnt + 2'd1;
                pack[{pk_cnt, 3'b000} +: 8] <= flash_data;
            end
            if (mem_valid && mem_ready) begin
                mem_valid <= 1'b0;
                mem_addr  <= mem_addr + 32'd4;
            end
            // pack is cleared on every emit so a partial word is zero-padded
            if (load_full) begin
                mem_valid <= 1'b1;
                mem_wdata <= {flash_data, pack[23:0]};
                mem_wstrb <= 4'hF;
                pack      <= '0;
            end
            if (load_part) begin
                mem_valid <= 1'b1;
                mem_wdata <= pack;
                mem_wstrb <= 4'((5'd1 << pk_cnt) - 5'd1);
                pk_cnt    <= '0;
                pack      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_flash_boot_loader.sv
// tb_flash_boot_loader: randomized copy runs checked against a byte-level model of the expected memory image.
module tb_flash_boot_loader;
    localparam logic [23:0] FB  = 24'h100000;
    localparam int          LEN = 22;
    localparam logic [31:0] MB  = 32'h00000100;
    localparam int          NW  = (LEN + 3) / 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        flash_setup_done = 1'b0, flash_data_ready = 1'b0, mem_ready = 1'b1;
    logic [7:0]  flash_data = 8'h00;
    logic [23:0] flash_addr;
    logic        flash_do_read, mem_valid, busy, done;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int          n_vec = 0, n_err = 0;
    int          gap = 1;
    logic [7:0]  salt = 8'h00;
    logic [31:0] wr_addr[$], wr_data[$];
    logic [3:0]  wr_strb[$];
    logic [23:0] rise_addr[$];
    int          cyc = 0, vcyc = 0, last_acc = 0, done_cyc = 0;
    logic        prev_dr = 1'b0, prev_done = 1'b0;
    logic        fl_act = 1'b0;
    logic [23:0] fl_a = '0;
    int          fl_c = 0;

    always #5 clk = ~clk;

    flash_boot_loader #(.FLASH_BASE(FB), .LEN_BYTES(LEN), .MEM_BASE(MB)) dut (
        .clk(clk), .rst_n(rst_n), .flash_setup_done(flash_setup_done),
        .flash_data_ready(flash_data_ready), .flash_data(flash_data),
        .flash_addr(flash_addr), .flash_do_read(flash_do_read),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .busy(busy), .done(done)
    );

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return a[7:0] ^ salt;
    endfunction

    function automatic logic [31:0] exp_data(input int i);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++)
            if (4 * i + k < LEN) w[8 * k +: 8] = fbyte(FB + 24'(4 * i + k));
        return w;
    endfunction

    function automatic logic [3:0] exp_strb(input int i);
        logic [3:0] s = '0;
        for (int k = 0; k < 4; k++) s[k] = (4 * i + k < LEN);
        return s;
    endfunction

    // flash reader: latches the address when do_read rises, then one byte every gap cycles
    initial forever begin
        @(negedge clk);
        flash_data_ready = 1'b0;
        if (!flash_do_read) fl_act = 1'b0;
        else if (!fl_act) begin
            fl_act = 1'b1;
            fl_a   = flash_addr;
            fl_c   = gap;
        end else if (fl_c > 1) fl_c--;
        else begin
            flash_data_ready = 1'b1;
            flash_data       = fbyte(fl_a);
            fl_a++;
            fl_c = gap;
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        cyc++;
        if (mem_valid) vcyc++;
        if (mem_valid && mem_ready) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_strb.push_back(mem_wstrb);
            last_acc = cyc;
        end
        if (done && !prev_done) done_cyc = cyc;
        if (flash_do_read && !prev_dr) rise_addr.push_back(flash_addr);
        prev_done = done;
        prev_dr   = flash_do_read;
    end

    task automatic restart(input int g, input logic [7:0] s);
        @(negedge clk);
        rst_n = 1'b0;
        flash_setup_done = 1'b0;
        mem_ready = 1'b1;
        gap = g;
        salt = s;
        @(negedge clk);
        #2;
        wr_addr.delete(); wr_data.delete(); wr_strb.delete(); rise_addr.delete();
        vcyc = 0; last_acc = 0; done_cyc = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_copy(input int pct, input int budget, output bit ok);
        ok = 1'b0;
        flash_setup_done = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            mem_ready = ($urandom_range(99) < pct);
            ok = done;
        end
        #2;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({flash_do_read, flash_addr} !== {1'b0, FB}) begin
            n_err++; $display("FAIL reset_flash got %b/%h want 0/%h", flash_do_read, flash_addr, FB);
        end
        n_vec++;
        if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== {1'b0, MB, 32'h0, 4'h0}) begin
            n_err++; $display("FAIL reset_mem got %b/%h/%h/%h want 0/%h/0/0", mem_valid, mem_addr, mem_wdata, mem_wstrb, MB);
        end
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL reset_status got %b%b want 00", busy, done);
        end
    endtask

    task automatic test_wait_setup;
        int bad = 0;
        bit ok;
        restart(1, 8'($urandom));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (flash_do_read || busy || mem_valid || done) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL setup_idle got %0d active cycles want 0", bad);
        end
        flash_setup_done = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({busy, flash_do_read, flash_addr} !== {2'b11, FB}) begin
            n_err++; $display("FAIL setup_start got %b%b/%h want 11/%h", busy, flash_do_read, flash_addr, FB);
        end
        run_copy(100, 500, ok);
        n_vec++;
        if (!ok || wr_addr.size() != NW) begin
            n_err++; $display("FAIL setup_copy got done=%0d writes=%0d want 1/%0d", ok, wr_addr.size(), NW);
        end
    endtask

    task automatic test_stream;
        bit ok;
        restart(1, 8'h00);
        run_copy(100, 500, ok);
        n_vec++;
        if (!ok || wr_addr.size() != NW) begin
            n_err++; $display("FAIL stream_count got done=%0d writes=%0d want 1/%0d", ok, wr_addr.size(), NW);
        end
        for (int i = 0; i < NW && i < wr_addr.size(); i++) begin
            n_vec++;
            if ({wr_addr[i], wr_data[i], wr_strb[i]} !== {MB + 32'(4 * i), exp_data(i), exp_strb(i)}) begin
                n_err++; $display("FAIL stream_word%0d got %h/%h/%h want %h/%h/%h", i, wr_addr[i], wr_data[i], wr_strb[i], MB + 32'(4 * i), exp_data(i), exp_strb(i));
            end
        end
        n_vec++;
        if (wr_data.size() < 1 || wr_data[0] !== 32'h03020100) begin
            n_err++; $display("FAIL stream_first got %h want 03020100", wr_data.size() > 0 ? wr_data[0] : 32'hx);
        end
        n_vec++;
        if (rise_addr.size() != 1 || rise_addr[0] !== FB) begin
            n_err++; $display("FAIL stream_single_read got %0d rises want 1 at %h", rise_addr.size(), FB);
        end
        n_vec++;
        if (done_cyc - last_acc != 2 || {busy, done} !== 2'b01) begin
            n_err++; $display("FAIL stream_done got lag=%0d busy/done=%b%b want 2/01", done_cyc - last_acc, busy, done);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        bit seen = 1'b0;
        restart(1, 8'h00);
        flash_setup_done = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = mem_valid;
        end
        mem_ready = 1'b0;
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL bp_first_valid got none want mem_valid within 200 cycles");
        end
        repeat (20) @(negedge clk);
        run_copy(100, 500, ok);
        n_vec++;
        if (rise_addr.size() < 2 || rise_addr[1] !== FB + 24'd7) begin
            n_err++; $display("FAIL bp_restart got %0d rises, second=%h want >=2, %h", rise_addr.size(), rise_addr.size() > 1 ? rise_addr[1] : 24'hx, FB + 24'd7);
        end
        n_vec++;
        if (!ok || wr_addr.size() != NW) begin
            n_err++; $display("FAIL bp_count got done=%0d writes=%0d want 1/%0d", ok, wr_addr.size(), NW);
        end
        for (int i = 0; i < NW && i < wr_addr.size(); i++) begin
            n_vec++;
            if ({wr_addr[i], wr_data[i], wr_strb[i]} !== {MB + 32'(4 * i), exp_data(i), exp_strb(i)}) begin
                n_err++; $display("FAIL bp_word%0d got %h/%h/%h want %h/%h/%h", i, wr_addr[i], wr_data[i], wr_strb[i], MB + 32'(4 * i), exp_data(i), exp_strb(i));
            end
        end
    endtask

    task automatic test_reset_midcopy;
        bit ok;
        logic [7:0] s = 8'($urandom);
        restart(2, s);
        flash_setup_done = 1'b1;
        for (int i = 0; i < 300 && wr_addr.size() < 2; i++) begin
            @(negedge clk);
            #2;
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({flash_do_read, mem_valid, busy, done, flash_addr, mem_addr, mem_wstrb} !== {4'b0000, FB, MB, 4'h0}) begin
            n_err++; $display("FAIL midreset_async got %b%b%b%b/%h/%h/%h want 0000/%h/%h/0", flash_do_read, mem_valid, busy, done, flash_addr, mem_addr, mem_wstrb, FB, MB);
        end
        restart(2, s);
        run_copy(100, 800, ok);
        n_vec++;
        if (!ok || wr_addr.size() != NW || rise_addr.size() < 1 || rise_addr[0] !== FB) begin
            n_err++; $display("FAIL midreset_restart got done=%0d writes=%0d want 1/%0d from %h", ok, wr_addr.size(), NW, FB);
        end
        for (int i = 0; i < NW && i < wr_addr.size(); i++) begin
            n_vec++;
            if ({wr_addr[i], wr_data[i], wr_strb[i]} !== {MB + 32'(4 * i), exp_data(i), exp_strb(i)}) begin
                n_err++; $display("FAIL midreset_word%0d got %h/%h/%h want %h/%h/%h", i, wr_addr[i], wr_data[i], wr_strb[i], MB + 32'(4 * i), exp_data(i), exp_strb(i));
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        restart(2, 8'($urandom));
        run_copy(100, 800, ok);
        n_vec++;
        if (!ok || wr_addr.size() != NW || vcyc != NW) begin
            n_err++; $display("FAIL b2b_count got done=%0d writes=%0d valid_cycles=%0d want 1/%0d/%0d", ok, wr_addr.size(), vcyc, NW, NW);
        end
        for (int i = 0; i < NW && i < wr_addr.size(); i++) begin
            n_vec++;
            if ({wr_addr[i], wr_data[i], wr_strb[i]} !== {MB + 32'(4 * i), exp_data(i), exp_strb(i)}) begin
                n_err++; $display("FAIL b2b_word%0d got %h/%h/%h want %h/%h/%h", i, wr_addr[i], wr_data[i], wr_strb[i], MB + 32'(4 * i), exp_data(i), exp_strb(i));
            end
        end
    endtask

    task automatic test_random;
        bit ok;
        int pct;
        for (int it = 0; it < 6; it++) begin
            restart(int'($urandom_range(4, 1)), 8'($urandom));
            pct = int'($urandom_range(90, 20));
            run_copy(pct, 3000, ok);
            n_vec++;
            if (!ok || wr_addr.size() != NW || {busy, done} !== 2'b01 || done_cyc - last_acc != 2) begin
                n_err++; $display("FAIL rand%0d_end got done=%0d writes=%0d busy/done=%b%b lag=%0d want 1/%0d/01/2", it, ok, wr_addr.size(), busy, done, done_cyc - last_acc, NW);
            end
            for (int i = 0; i < NW && i < wr_addr.size(); i++) begin
                n_vec++;
                if ({wr_addr[i], wr_data[i], wr_strb[i]} !== {MB + 32'(4 * i), exp_data(i), exp_strb(i)}) begin
                    n_err++; $display("FAIL rand%0d_word%0d got %h/%h/%h want %h/%h/%h", it, i, wr_addr[i], wr_data[i], wr_strb[i], MB + 32'(4 * i), exp_data(i), exp_strb(i));
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_wait_setup;
        test_stream;
        test_backpressure;
        test_reset_midcopy;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
